// File: rtl/river_pkg.sv
// Shared constants and types for the river fetch-stage predictor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package river_pkg;

  // Return-address stack geometry; pointer width is log2 of the depth.
  localparam int RET_STACK_SIZE        = 16;
  localparam int RET_PRED_POINTER_SIZE = 4;

  // Reset vector: an empty stack predicts a return into the kernel entry.
  localparam logic [31:0] kernel_adr = 32'hF0000000;

  typedef logic [RET_PRED_POINTER_SIZE-1:0] ret_ptr_t;
  typedef logic [RET_PRED_POINTER_SIZE:0]   ret_cnt_t;

endpackage

// File: rtl/ret_stack_ptr.sv
// Pointer/count next-state for one RAS pointer pair (spec or commit side).
// Latency: purely combinational; the caller registers the result.
// Backpressure: none; push saturates the count, pop on empty is a no-op.
module ret_stack_ptr
  import river_pkg::*;
#(
  parameter int DEPTH = RET_STACK_SIZE,
  parameter int PTR_W = RET_PRED_POINTER_SIZE
) (
  input  logic [PTR_W-1:0] i_sp,
  input  logic [PTR_W:0]   i_cnt,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [PTR_W-1:0] o_sp_nxt,
  output logic [PTR_W:0]   o_cnt_nxt
);

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  logic w_empty;
  logic w_full;

  // Push advances (overwriting the oldest slot when full), pop retreats unless
  // empty, push+pop on a non-empty stack replaces the top in place.
  always_comb begin
    w_empty   = (i_cnt == '0);
    w_full    = (i_cnt == CNT_MAX);
    o_sp_nxt  = i_sp;
    o_cnt_nxt = i_cnt;
    if (i_push && (!i_pop || w_empty)) begin
      o_sp_nxt = i_sp + PTR_W'(1);
      if (!w_full) begin
        o_cnt_nxt = i_cnt + (PTR_W+1)'(1);
      end
    end else if (i_pop && !i_push && !w_empty) begin
      o_sp_nxt  = i_sp - PTR_W'(1);
      o_cnt_nxt = i_cnt - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/ret_addr_stack.sv
// Speculative return-address stack with committed pointer copy for flush recovery.
// Latency: top_adr_o is a combinational read; a push is visible the next cycle.
// Backpressure: none; an op is accepted every cycle. Optional macro RET_STACK_STATS_EN adds overflow/underflow counters.
module ret_addr_stack
  import river_pkg::*;
#(
  parameter int DEPTH = RET_STACK_SIZE,
  parameter int PTR_W = RET_PRED_POINTER_SIZE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        spec_push_i,
  input  logic [31:0] spec_push_adr_i,
  input  logic        spec_pop_i,
  output logic [31:0] top_adr_o,
  output logic        top_valid_o,
  input  logic        commit_push_i,
  input  logic        commit_pop_i,
  input  logic        flush_i,
  output logic        full_o,
  output logic        empty_o
`ifdef RET_STACK_STATS_EN
  ,
  output logic [15:0] ovf_cnt_o,
  output logic [15:0] unf_cnt_o
`endif
);

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_entries [DEPTH];
  logic [PTR_W-1:0] r_sp_spec;
  logic [PTR_W:0]   r_cnt_spec;
  logic [PTR_W-1:0] r_sp_commit;
  logic [PTR_W:0]   r_cnt_commit;

  logic [PTR_W-1:0] w_sp_spec_op;
  logic [PTR_W:0]   w_cnt_spec_op;
  logic [PTR_W-1:0] w_sp_commit_nxt;
  logic [PTR_W:0]   w_cnt_commit_nxt;
  logic             w_empty;
  logic             w_full;
  logic [PTR_W-1:0] w_rd_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic             w_wr_en;

  ret_stack_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_spec_ptr (
    .i_sp      (r_sp_spec),
    .i_cnt     (r_cnt_spec),
    .i_push    (spec_push_i),
    .i_pop     (spec_pop_i),
    .o_sp_nxt  (w_sp_spec_op),
    .o_cnt_nxt (w_cnt_spec_op)
  );

  ret_stack_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_commit_ptr (
    .i_sp      (r_sp_commit),
    .i_cnt     (r_cnt_commit),
    .i_push    (commit_push_i),
    .i_pop     (commit_pop_i),
    .o_sp_nxt  (w_sp_commit_nxt),
    .o_cnt_nxt (w_cnt_commit_nxt)
  );

  assign w_empty  = (r_cnt_spec == '0);
  assign w_full   = (r_cnt_spec == CNT_MAX);
  assign w_rd_idx = r_sp_spec - PTR_W'(1);
  // Push+pop on a non-empty stack overwrites the current top slot instead of the free slot.
  assign w_wr_idx = (spec_pop_i && !w_empty) ? w_rd_idx : r_sp_spec;
  assign w_wr_en  = spec_push_i && !flush_i;

  assign top_adr_o   = r_entries[w_rd_idx];
  assign top_valid_o = !w_empty;
  assign empty_o     = w_empty;
  assign full_o      = w_full;

  // Pointer pairs; flush reloads the spec pair from the commit pair's next value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sp_spec    <= '0;
      r_cnt_spec   <= '0;
      r_sp_commit  <= '0;
      r_cnt_commit <= '0;
    end else begin
      r_sp_commit  <= w_sp_commit_nxt;
      r_cnt_commit <= w_cnt_commit_nxt;
      if (flush_i) begin
        r_sp_spec  <= w_sp_commit_nxt;
        r_cnt_spec <= w_cnt_commit_nxt;
      end else begin
        r_sp_spec  <= w_sp_spec_op;
        r_cnt_spec <= w_cnt_spec_op;
      end
    end
  end

  // Entry storage; squashed pushes are not undone on flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= kernel_adr;
      end
    end else if (w_wr_en) begin
      r_entries[w_wr_idx] <= spec_push_adr_i;
    end
  end

`ifdef RET_STACK_STATS_EN
  logic [15:0] r_ovf_cnt;
  logic [15:0] r_unf_cnt;

  // Saturating counts of pushes onto a full stack and lone pops on an empty one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (!flush_i) begin
      if (spec_push_i && w_full && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
      if (spec_pop_i && !spec_push_i && w_empty && (r_unf_cnt != 16'hFFFF)) begin
        r_unf_cnt <= r_unf_cnt + 16'd1;
      end
    end
  end

  assign ovf_cnt_o = r_ovf_cnt;
  assign unf_cnt_o = r_unf_cnt;
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: directed ops with a scoreboard of expected outputs.
module tb_ret_addr_stack;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spec_push_i = 1'b0;
  logic [31:0] spec_push_adr_i = '0;
  logic        spec_pop_i = 1'b0;
  logic [31:0] top_adr_o;
  logic        top_valid_o;
  logic        commit_push_i = 1'b0;
  logic        commit_pop_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        full_o;
  logic        empty_o;
`ifdef RET_STACK_STATS_EN
  logic [15:0] ovf_cnt_o;
  logic [15:0] unf_cnt_o;
`endif

  localparam logic [31:0] KADR = 32'hF0000000;

  ret_addr_stack dut (
    .clock           (clock),
    .reset           (reset),
    .spec_push_i     (spec_push_i),
    .spec_push_adr_i (spec_push_adr_i),
    .spec_pop_i      (spec_pop_i),
    .top_adr_o       (top_adr_o),
    .top_valid_o     (top_valid_o),
    .commit_push_i   (commit_push_i),
    .commit_pop_i    (commit_pop_i),
    .flush_i         (flush_i),
    .full_o          (full_o),
    .empty_o         (empty_o)
`ifdef RET_STACK_STATS_EN
    ,
    .ovf_cnt_o       (ovf_cnt_o),
    .unf_cnt_o       (unf_cnt_o)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] adr;
    logic        vld;
    logic        full;
    logic        empty;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic op(input logic push, input logic [31:0] adr, input logic pop,
                    input logic cpush, input logic cpop, input logic flush,
                    input logic [31:0] e_adr, input logic e_vld, input logic e_full,
                    input logic e_empty, input string name);
    exp_t e;
    @(negedge clock);
    spec_push_i     = push;
    spec_push_adr_i = adr;
    spec_pop_i      = pop;
    commit_push_i   = cpush;
    commit_pop_i    = cpop;
    flush_i         = flush;
    e.cyc   = cyc;
    e.adr   = e_adr;
    e.vld   = e_vld;
    e.full  = e_full;
    e.empty = e_empty;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the queued expectation for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_tests++;
        if (top_adr_o !== e.adr || top_valid_o !== e.vld || full_o !== e.full || empty_o !== e.empty) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got adr=%h vld=%b full=%b empty=%b, expected adr=%h vld=%b full=%b empty=%b",
                   e.name, cyc, top_adr_o, top_valid_o, full_o, empty_o, e.adr, e.vld, e.full, e.empty);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state.
    op(0, 0, 0, 0, 0, 0, KADR, 0, 0, 1, "reset_idle");

    // LIFO order over three entries.
    op(1, 32'h100, 0, 0, 0, 0, KADR,     0, 0, 1, "push_100");
    op(1, 32'h200, 0, 0, 0, 0, 32'h100, 1, 0, 0, "push_200");
    op(1, 32'h300, 0, 0, 0, 0, 32'h200, 1, 0, 0, "push_300");
    op(0, 0, 1, 0, 0, 0, 32'h300, 1, 0, 0, "pop_300");
    op(0, 0, 1, 0, 0, 0, 32'h200, 1, 0, 0, "pop_200");
    op(0, 0, 1, 0, 0, 0, 32'h100, 1, 0, 0, "pop_100");
    op(0, 0, 0, 0, 0, 0, KADR,     0, 0, 1, "empty_after_pops");
    // Pop on empty: no underflow wrap.
    op(0, 0, 1, 0, 0, 0, KADR,     0, 0, 1, "pop_on_empty");
    op(0, 0, 0, 0, 0, 0, KADR,     0, 0, 1, "after_pop_on_empty");

    // Fill past capacity: oldest entry is overwritten, count saturates.
    for (int i = 0; i < 17; i++) begin
      op(1, 32'h1000 + 4 * i, 0, 0, 0, 0,
         (i == 0) ? KADR : 32'h1000 + 4 * (i - 1), i != 0, i == 16, i == 0, "ring_push");
    end
    for (int j = 0; j < 16; j++) begin
      op(0, 0, 1, 0, 0, 0, 32'h1040 - 4 * j, 1, j == 0, 0, "ring_pop");
    end
    op(0, 0, 0, 0, 0, 0, 32'h1040, 0, 0, 1, "ring_empty");

    // Push+pop in one cycle replaces the top.
    op(1, 32'hA0, 0, 0, 0, 0, 32'h1040, 0, 0, 1, "push_a0");
    op(1, 32'hB0, 1, 0, 0, 0, 32'hA0,   1, 0, 0, "pushpop_top_a0");
    op(0, 0, 0, 0, 0, 0, 32'hB0,   1, 0, 0, "pushpop_top_b0");
    op(0, 0, 1, 0, 0, 0, 32'hB0,   1, 0, 0, "pop_b0");
    op(0, 0, 0, 0, 0, 0, 32'h1040, 0, 0, 1, "pushpop_count_one");

    // Flush restores the committed pointer.
    op(0, 0, 0, 0, 0, 1, 32'h1040, 0, 0, 1, "flush_sync");
    op(1, 32'h10, 0, 0, 0, 0, 32'h103C, 0, 0, 1, "push_10");
    op(1, 32'h20, 0, 0, 0, 0, 32'h10,   1, 0, 0, "push_20");
    op(0, 0, 0, 1, 0, 0, 32'h20, 1, 0, 0, "commit_push");
    op(0, 0, 0, 0, 0, 1, 32'h20, 1, 0, 0, "flush");
    op(0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0, "flush_restore");
    // Flush with a same-cycle commit push; the spec push must be ignored.
    op(1, 32'hDEAD, 0, 1, 0, 1, 32'h10, 1, 0, 0, "flush_commit_push");
    op(0, 0, 0, 0, 0, 0, 32'h20, 1, 0, 0, "flush_with_commit");
    op(0, 0, 1, 0, 0, 0, 32'h20, 1, 0, 0, "pop_20");
    op(0, 0, 1, 0, 0, 0, 32'h10, 1, 0, 0, "pop_10");
    op(0, 0, 1, 0, 0, 0, 32'h103C, 0, 0, 1, "pop_on_empty_2");
    op(0, 0, 0, 0, 0, 0, 32'h103C, 0, 0, 1, "final_idle");

    @(negedge clock);
    #5;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

`ifdef RET_STACK_STATS_EN
    n_tests++;
    if (ovf_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL ovf_cnt: got %0d, expected 1", ovf_cnt_o);
    end
    n_tests++;
    if (unf_cnt_o !== 16'd2) begin
      n_fail++;
      $display("FAIL unf_cnt: got %0d, expected 2", unf_cnt_o);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
